// File: rtl/vdmem_pkg.sv
// Shared types and default geometry for the vector data memory slice.
package vdmem_pkg;

    localparam int unsigned VDMEM_R  = 6;
    localparam int unsigned VDMEM_N  = 8;
    localparam int unsigned VDMEM_I  = 32;
    localparam int unsigned VDMEM_AW = 8;

    typedef enum logic [1:0] {LOAD, RUN, DUMP, DONE} vdmem_state_t;

    typedef logic [VDMEM_R-1:0][VDMEM_N-1:0] vword_t;

endpackage

// File: rtl/vdmem_if.sv
// Dump-port bundle: valid/ready word stream plus the completion level.
interface vdmem_if #(
    parameter int unsigned R  = 6,
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 8
);
    logic                  DumpValid;
    logic                  DumpReady;
    logic [AW-1:0]         DumpAddr;
    logic [R-1:0][N-1:0]   DumpData;
    logic                  DumpDone;

    modport master (
        output DumpValid, DumpAddr, DumpData, DumpDone,
        input  DumpReady
    );

    modport slave (
        input  DumpValid, DumpAddr, DumpData, DumpDone,
        output DumpReady
    );
endinterface

// File: rtl/vdmem_dump_streamer.sv
// Walks the dump window and presents one registered word at a time on a
// valid/ready port; the pointer wraps modulo DEPTH.
module vdmem_dump_streamer #(
    parameter int unsigned R          = 6,
    parameter int unsigned N          = 8,
    parameter int unsigned AW         = 8,
    parameter int unsigned DUMP_BASE  = 0,
    parameter int unsigned DUMP_WORDS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic                i_ready,
    input  logic [R-1:0][N-1:0] i_rd_data,
    output logic [AW-1:0]       o_rd_addr,
    output logic                o_valid,
    output logic [AW-1:0]       o_addr,
    output logic [R-1:0][N-1:0] o_data,
    output logic                o_last
);
    localparam logic [AW-1:0] C_BASE     = AW'(DUMP_BASE);
    localparam logic [AW-1:0] C_LAST_CNT = AW'(DUMP_WORDS - 1);

    logic                r_started;
    logic                r_valid;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       r_cnt;
    logic [R-1:0][N-1:0] r_data;
    logic                w_xfer;

    assign w_xfer    = r_valid && i_ready;
    assign o_rd_addr = r_started ? (r_addr + AW'(1)) : C_BASE;
    assign o_last    = w_xfer && (r_cnt == '0);
    assign o_valid   = r_valid;
    assign o_addr    = r_addr;
    assign o_data    = r_data;

    // r_cnt holds the number of words still to present after the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_started <= 1'b0;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
        end else if (!i_en) begin
            r_started <= 1'b0;
            r_valid   <= 1'b0;
        end else if (!r_started) begin
            r_started <= 1'b1;
            r_valid   <= 1'b1;
            r_addr    <= o_rd_addr;
            r_data    <= i_rd_data;
            r_cnt     <= C_LAST_CNT;
        end else if (w_xfer) begin
            if (r_cnt != '0) begin
                r_addr <= o_rd_addr;
                r_data <= i_rd_data;
                r_cnt  <= r_cnt - AW'(1);
            end else begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/vector_data_memory.sv
// Vector data memory: host preload, CPU read/write during RUN, then result dump.
// Optional VDMEM_ERR_EN adds a sticky AddrErr flag and suppresses out-of-range stores.
module vector_data_memory
    import vdmem_pkg::*;
#(
    parameter int unsigned R          = VDMEM_R,
    parameter int unsigned N          = VDMEM_N,
    parameter int unsigned I          = VDMEM_I,
    parameter int unsigned AW         = VDMEM_AW,
    parameter int unsigned DUMP_BASE  = 0,
    parameter int unsigned DUMP_WORDS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [I-1:0]        Address,
    input  logic [R-1:0][N-1:0] WriteData,
    input  logic                MemWriteM,
    input  logic                EndFlag,
    output logic [R-1:0][N-1:0] ReadData,
    input  logic                HostWe,
    input  logic [AW-1:0]       HostAddr,
    input  logic [R-1:0][N-1:0] HostWData,
    vdmem_if.master             dump,
    output logic                Busy
`ifdef VDMEM_ERR_EN
    ,
    output logic                AddrErr
`endif
);
    localparam int unsigned DEPTH = 2 ** AW;

    vdmem_state_t        r_state;
    vdmem_state_t        w_next_state;
    logic [R-1:0][N-1:0] r_mem [DEPTH];

    logic                w_mem_we;
    logic [AW-1:0]       w_mem_waddr;
    logic [R-1:0][N-1:0] w_mem_wdata;
    logic                w_start_run;
    logic                w_err_set;
    logic [AW-1:0]       w_cpu_idx;
    logic                w_addr_oor;
    logic [AW-1:0]       w_dump_rd_addr;
    logic                w_dump_last;

    assign w_cpu_idx  = Address[AW-1:0];
    assign w_addr_oor = |Address[I-1:AW];
    assign ReadData   = r_mem[w_cpu_idx];
    assign Busy       = (r_state == RUN) || (r_state == DUMP);
    assign dump.DumpDone = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (reset) r_state <= LOAD;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_mem_waddr  = HostAddr;
        w_mem_wdata  = HostWData;
        w_start_run  = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            LOAD, DONE: begin
                w_mem_we = HostWe;
                if (start) begin
                    w_start_run  = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_mem_waddr = w_cpu_idx;
                w_mem_wdata = WriteData;
`ifdef VDMEM_ERR_EN
                w_err_set = MemWriteM && w_addr_oor;
                w_mem_we  = MemWriteM && !w_addr_oor;
`else
                w_mem_we  = MemWriteM;
`endif
                if (EndFlag) w_next_state = DUMP;
            end
            DUMP: begin
                if (w_dump_last) w_next_state = DONE;
            end
            default: w_next_state = LOAD;
        endcase
    end

    // Storage is deliberately not reset so a mid-run reset keeps the image.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

`ifdef VDMEM_ERR_EN
    logic r_addr_err;
    assign AddrErr = r_addr_err;

    always_ff @(posedge clk) begin
        if (reset || w_start_run) r_addr_err <= 1'b0;
        else if (w_err_set)       r_addr_err <= 1'b1;
    end
`else
    logic w_unused_err;
    assign w_unused_err = w_addr_oor ^ w_err_set ^ w_start_run;
`endif

    vdmem_dump_streamer #(
        .R          (R),
        .N          (N),
        .AW         (AW),
        .DUMP_BASE  (DUMP_BASE),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_streamer (
        .clk       (clk),
        .reset     (reset),
        .i_en      (r_state == DUMP),
        .i_ready   (dump.DumpReady),
        .i_rd_data (r_mem[w_dump_rd_addr]),
        .o_rd_addr (w_dump_rd_addr),
        .o_valid   (dump.DumpValid),
        .o_addr    (dump.DumpAddr),
        .o_data    (dump.DumpData),
        .o_last    (w_dump_last)
    );
endmodule

// File: tb/tb_vector_data_memory.sv
// Directed bench: two instances share CPU/host inputs, dump windows 0..3 and 254..1.
module tb_vector_data_memory;
    import vdmem_pkg::*;

    typedef struct {
        logic        host_we;
        logic [7:0]  host_addr;
        logic [47:0] host_wdata;
        logic        mem_we;
        logic [31:0] addr;
        logic [47:0] wdata;
        logic        chk;
        logic [47:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, MemWriteM, EndFlag, HostWe;
    logic [31:0] Address;
    vword_t      WriteData, HostWData, rd_a, rd_b;
    logic [7:0]  HostAddr;
    logic        busy_a, busy_b;
`ifdef VDMEM_ERR_EN
    logic        err_a, err_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vdmem_if #(.R(6), .N(8), .AW(8)) dif_a ();
    vdmem_if #(.R(6), .N(8), .AW(8)) dif_b ();

    always #5 clk = ~clk;

    vector_data_memory #(.DUMP_BASE(0), .DUMP_WORDS(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .Address(Address),
        .WriteData(WriteData), .MemWriteM(MemWriteM), .EndFlag(EndFlag),
        .ReadData(rd_a), .HostWe(HostWe), .HostAddr(HostAddr),
        .HostWData(HostWData), .dump(dif_a),
`ifdef VDMEM_ERR_EN
        .AddrErr(err_a),
`endif
        .Busy(busy_a)
    );

    vector_data_memory #(.DUMP_BASE(254), .DUMP_WORDS(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .Address(Address),
        .WriteData(WriteData), .MemWriteM(MemWriteM), .EndFlag(EndFlag),
        .ReadData(rd_b), .HostWe(HostWe), .HostAddr(HostAddr),
        .HostWData(HostWData), .dump(dif_b),
`ifdef VDMEM_ERR_EN
        .AddrErr(err_b),
`endif
        .Busy(busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [47:0] W_A5 = 48'hA5A5_A5A5_A5A5;
    localparam logic [47:0] W_11 = 48'h1111_1111_1111;
    localparam logic [47:0] W_22 = 48'h2222_2222_2222;
    localparam logic [47:0] W_77 = 48'h7777_7777_7777;
    localparam logic [47:0] W_FE = 48'hFEFE_FEFE_FEFE;
    localparam logic [47:0] W_FF = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] W_1  = 48'h0102_0304_0506;
    localparam logic [47:0] W_0  = 48'h0605_0403_0201;

    vec_t        vecs [9];
    logic [47:0] exp_a [4];
    logic [47:0] exp_b [4];
    logic [7:0]  exp_addr_b [4];
    logic        pat [4];

    initial begin
        vecs[0] = '{1'b1, 8'd3,   W_A5, 1'b0, 32'd3,   48'h0, 1'b0, 48'h0};
        vecs[1] = '{1'b1, 8'd0,   W_11, 1'b0, 32'd3,   48'h0, 1'b1, W_A5};
        vecs[2] = '{1'b0, 8'd0,   48'h0, 1'b1, 32'd3,  48'h0, 1'b1, W_A5};
        vecs[3] = '{1'b1, 8'd255, W_FF, 1'b0, 32'd3,   48'h0, 1'b1, W_A5};
        vecs[4] = '{1'b1, 8'd254, W_FE, 1'b0, 32'd0,   48'h0, 1'b1, W_11};
        vecs[5] = '{1'b1, 8'd1,   W_1,  1'b0, 32'd255, 48'h0, 1'b1, W_FF};
        vecs[6] = '{1'b0, 8'd0,   48'h0, 1'b0, 32'd259, 48'h0, 1'b1, W_A5};
        vecs[7] = '{1'b0, 8'd0,   48'h0, 1'b0, 32'd1,  48'h0, 1'b1, W_1};
        vecs[8] = '{1'b0, 8'd0,   48'h0, 1'b0, 32'd254, 48'h0, 1'b1, W_FE};
        exp_a      = '{W_0, W_1, W_22, 48'h0};
        exp_b      = '{W_FE, W_FF, W_0, W_1};
        exp_addr_b = '{8'd254, 8'd255, 8'd0, 8'd1};
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; MemWriteM = 1'b0; EndFlag = 1'b0;
        HostWe = 1'b0; HostAddr = '0; HostWData = '0; Address = '0; WriteData = '0;
        dif_a.DumpReady = 1'b0; dif_b.DumpReady = 1'b0;
        tick(); tick();

        chk("rst_valid", 64'(dif_a.DumpValid), 64'd0);
        chk("rst_done",  64'(dif_a.DumpDone),  64'd0);
        chk("rst_busy",  64'(busy_a),          64'd0);
        chk("rst_addr",  64'(dif_a.DumpAddr),  64'd0);
        chk("rst_data",  64'(dif_a.DumpData),  64'd0);
        chk("rst_addr_b", 64'(dif_b.DumpAddr), 64'd0);
        reset = 1'b0;

        // Preload in LOAD with combinational reads; LOAD-state CPU store is ignored.
        for (int unsigned i = 0; i < 9; i++) begin
            HostWe = vecs[i].host_we; HostAddr = vecs[i].host_addr;
            HostWData = vecs[i].host_wdata; MemWriteM = vecs[i].mem_we;
            Address = vecs[i].addr; WriteData = vecs[i].wdata;
            #1;
            if (vecs[i].chk) chk($sformatf("load_rd[%0d]", i), 64'(rd_a), 64'(vecs[i].exp_rd));
            tick();
        end
        HostWe = 1'b0; MemWriteM = 1'b0;

        // start together with HostWe: write commits and RUN begins.
        start = 1'b1; HostWe = 1'b1; HostAddr = 8'd2; HostWData = W_22;
        tick();
        start = 1'b0; HostWe = 1'b0;
        chk("run_busy", 64'(busy_a), 64'd1);
        Address = 32'd2; #1;
        chk("start_hostwe_rd", 64'(rd_a), 64'(W_22));

        // RUN store wins; HostWe ignored.
        MemWriteM = 1'b1; Address = 32'd3; WriteData = '0;
        HostWe = 1'b1; HostAddr = 8'd3; HostWData = W_77;
        tick();
        MemWriteM = 1'b0; HostWe = 1'b0; #1;
        chk("run_store_rd", 64'(rd_a), 64'd0);

        // Store plus EndFlag in the same cycle, then a free-flowing dump.
        MemWriteM = 1'b1; Address = 32'd0; WriteData = W_0; EndFlag = 1'b1;
        dif_a.DumpReady = 1'b1; dif_b.DumpReady = 1'b1;
        tick();
        MemWriteM = 1'b0; EndFlag = 1'b0;
        chk("dump_c0_valid", 64'(dif_a.DumpValid), 64'd0);
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("dump_valid[%0d]", k),  64'(dif_a.DumpValid), 64'd1);
            chk($sformatf("dump_addr[%0d]", k),   64'(dif_a.DumpAddr),  64'(k));
            chk($sformatf("dump_data[%0d]", k),   64'(dif_a.DumpData),  64'(exp_a[k]));
            chk($sformatf("wrap_addr[%0d]", k),   64'(dif_b.DumpAddr),  64'(exp_addr_b[k]));
            chk($sformatf("wrap_data[%0d]", k),   64'(dif_b.DumpData),  64'(exp_b[k]));
        end
        tick();
        chk("dump_done",       64'(dif_a.DumpDone),  64'd1);
        chk("dump_end_valid",  64'(dif_a.DumpValid), 64'd0);
        chk("dump_end_busy",   64'(busy_a),          64'd0);

        // Second run: stalled dump with ready pattern 1,0,0,1.
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_done_clr", 64'(dif_a.DumpDone), 64'd0);
        chk("restart_busy",     64'(busy_a),         64'd1);
        EndFlag = 1'b1; tick(); EndFlag = 1'b0;
        begin
            int unsigned n_xfer = 0;
            logic        held = 1'b0;
            logic        seen_done = 1'b0;
            logic [7:0]  h_addr = '0;
            logic [47:0] h_data = '0;
            for (int unsigned c = 0; c < 40; c++) begin
                dif_a.DumpReady = pat[c % 4];
                #1;
                if (dif_a.DumpDone) begin
                    seen_done = 1'b1;
                    break;
                end
                if (dif_a.DumpValid) begin
                    if (held) begin
                        chk("stall_addr_hold", 64'(dif_a.DumpAddr), 64'(h_addr));
                        chk("stall_data_hold", 64'(dif_a.DumpData), 64'(h_data));
                    end
                    if (dif_a.DumpReady) begin
                        if (n_xfer < 4) begin
                            chk($sformatf("stall_xfer_addr[%0d]", n_xfer), 64'(dif_a.DumpAddr), 64'(n_xfer));
                            chk($sformatf("stall_xfer_data[%0d]", n_xfer), 64'(dif_a.DumpData), 64'(exp_a[n_xfer]));
                        end
                        n_xfer++;
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                        h_addr = dif_a.DumpAddr;
                        h_data = dif_a.DumpData;
                    end
                end
                tick();
            end
            chk("stall_done_seen", 64'(seen_done), 64'd1);
            chk("stall_xfer_count", 64'(n_xfer), 64'd4);
        end

        // Third run: reset while the second dump word is presented.
        dif_a.DumpReady = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        EndFlag = 1'b1; tick(); EndFlag = 1'b0;
        tick(); tick();
        chk("rst_mid_addr", 64'(dif_a.DumpAddr), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", 64'(dif_a.DumpValid), 64'd0);
        chk("rst_mid_busy",  64'(busy_a),          64'd0);
        chk("rst_mid_done",  64'(dif_a.DumpDone),  64'd0);
        Address = 32'd0; #1;
        chk("rst_mid_mem", 64'(rd_a), 64'(W_0));
        MemWriteM = 1'b1; WriteData = W_77;
        tick();
        MemWriteM = 1'b0; #1;
        chk("rst_mid_load_ignore", 64'(rd_a), 64'(W_0));

`ifdef VDMEM_ERR_EN
        start = 1'b1; tick(); start = 1'b0;
        chk("err_clear", 64'(err_a), 64'd0);
        MemWriteM = 1'b1; Address = 32'd256; WriteData = W_FF;
        tick();
        MemWriteM = 1'b0;
        chk("err_set", 64'(err_a), 64'd1);
        Address = 32'd0; #1;
        chk("err_suppressed", 64'(rd_a), 64'(W_0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
